hazard_stall_ctrl: RTL and testbench

Pipeline interlock controller for the 5-stage core. It computes the D-stage stall from the Tuse/Tnew register-dependency rule, and sequences the multi-cycle multiply/divide unit with a busy-cycle FSM. It drives the enable and flush controls of the PC and of the F/D, D/E, E/M and M/W pipeline registers. Forwarding is out of scope: this block only decides stall versus proceed.

---
 rtl/hazard_stall_ctrl_pkg.sv | 37 +++
 rtl/hazard_stall_ctrl_md_busy_fsm.sv | 71 +++++++
 rtl/hazard_stall_ctrl.sv | 91 +++++++++
 tb/tb_hazard_stall_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module  : hazard_stall_ctrl_pkg
// Brief   : Shared Tuse/Tnew encodings, MDU latency defaults and FSM states.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package hazard_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } t_time_e;

  localparam logic [1:0] TUSE_NONE = T3;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // A consumer stalls only if the producer's result arrives later than it is needed.
  function automatic logic dep_stall(input logic [4:0] src, input logic [1:0] tuse,
                                     input logic [4:0] dst, input logic [1:0] tnew);
    if (src == 5'd0 || tuse == TUSE_NONE)
      return 1'b0;
    return (src == dst) && (tuse < tnew);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_stall_ctrl_md_busy_fsm.sv
//------------------------------------------------------------------------------
// Module  : md_busy_fsm
// Brief   : IDLE/BUSY sequencer counting multiply/divide latency after E start.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module md_busy_fsm
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic E_md_start,
  input  logic E_md_is_div,
  output logic md_busy
);

  localparam logic [CNT_W-1:0] C_MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] C_DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

  md_state_e        r_state;
  md_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A start seen while busy is dropped: the running count is never reloaded.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      MD_IDLE: begin
        if (E_md_start) begin
          w_state_nxt = MD_BUSY;
          w_cnt_nxt   = E_md_is_div ? C_DIV_LOAD : C_MULT_LOAD;
        end
      end
      MD_BUSY: begin
        if (r_cnt == C_ONE) begin
          w_state_nxt = MD_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - C_ONE;
        end
      end
      default: begin
        w_state_nxt = MD_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign md_busy = (r_state == MD_BUSY);

endmodule

`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
//------------------------------------------------------------------------------
// Module  : hazard_stall_ctrl
// Brief   : D-stage interlock (Tuse/Tnew + MDU busy); STALL_STAT_EN adds stall_cnt.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_rs_Tuse,
  input  logic [1:0] D_rt_Tuse,
  input  logic       D_is_md,
  input  logic [4:0] E_A3,
  input  logic [1:0] E_Tnew,
  input  logic [4:0] M_A3,
  input  logic [1:0] M_Tnew,
  input  logic       E_md_start,
  input  logic       E_md_is_div,
  output logic       PC_WrEn,
  output logic       FD_WrEn,
  output logic       DE_flush,
  output logic       EM_WrEn,
  output logic       MW_WrEn,
  output logic       md_busy
`ifdef STALL_STAT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  logic w_stall_rs;
  logic w_stall_rt;
  logic w_stall_md;
  logic w_stall;
  logic w_md_busy;

  md_busy_fsm #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_fsm (
    .clk         (clk),
    .reset       (reset),
    .E_md_start  (E_md_start),
    .E_md_is_div (E_md_is_div),
    .md_busy     (w_md_busy)
  );

  assign w_stall_rs = dep_stall(D_rs, D_rs_Tuse, E_A3, E_Tnew) |
                      dep_stall(D_rs, D_rs_Tuse, M_A3, M_Tnew);
  assign w_stall_rt = dep_stall(D_rt, D_rt_Tuse, E_A3, E_Tnew) |
                      dep_stall(D_rt, D_rt_Tuse, M_A3, M_Tnew);
  // A start in E counts as busy already, so a back-to-back MD op cannot slip in.
  assign w_stall_md = D_is_md & (w_md_busy | E_md_start);

  // Holding reset low masks every stall cause.
  assign w_stall = reset & (w_stall_rs | w_stall_rt | w_stall_md);

  assign PC_WrEn  = ~w_stall;
  assign FD_WrEn  = ~w_stall;
  assign DE_flush = w_stall;
  assign EM_WrEn  = 1'b1;
  assign MW_WrEn  = 1'b1;
  assign md_busy  = w_md_busy;

`ifdef STALL_STAT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_hazard_stall_ctrl
// Brief   : Directed self-checking bench for the hazard/stall controller.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_hazard_stall_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] D_rs, D_rt, E_A3, M_A3;
  logic [1:0] D_rs_Tuse, D_rt_Tuse, E_Tnew, M_Tnew;
  logic       D_is_md, E_md_start, E_md_is_div;
  logic       PC_WrEn, FD_WrEn, DE_flush, EM_WrEn, MW_WrEn, md_busy;
`ifdef STALL_STAT_EN
  logic [31:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  hazard_stall_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .D_rs        (D_rs),
    .D_rt        (D_rt),
    .D_rs_Tuse   (D_rs_Tuse),
    .D_rt_Tuse   (D_rt_Tuse),
    .D_is_md     (D_is_md),
    .E_A3        (E_A3),
    .E_Tnew      (E_Tnew),
    .M_A3        (M_A3),
    .M_Tnew      (M_Tnew),
    .E_md_start  (E_md_start),
    .E_md_is_div (E_md_is_div),
    .PC_WrEn     (PC_WrEn),
    .FD_WrEn     (FD_WrEn),
    .DE_flush    (DE_flush),
    .EM_WrEn     (EM_WrEn),
    .MW_WrEn     (MW_WrEn),
    .md_busy     (md_busy)
`ifdef STALL_STAT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // exp_stall: 1 expects PC/FD held and D/E flushed
  task automatic check_stall(input string tag, input logic exp_stall);
    check({tag, ".pc"}, {31'd0, PC_WrEn}, {31'd0, ~exp_stall});
    check({tag, ".fd"}, {31'd0, FD_WrEn}, {31'd0, ~exp_stall});
    check({tag, ".de"}, {31'd0, DE_flush}, {31'd0, exp_stall});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    D_rs = 5'd0; D_rt = 5'd0; D_rs_Tuse = 2'd3; D_rt_Tuse = 2'd3;
    D_is_md = 1'b0; E_A3 = 5'd0; E_Tnew = 2'd0; M_A3 = 5'd0; M_Tnew = 2'd0;
    E_md_start = 1'b0; E_md_is_div = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    #12;
    check("rst.busy", {31'd0, md_busy}, 32'd0);
    check("rst.em", {31'd0, EM_WrEn}, 32'd1);
    check("rst.mw", {31'd0, MW_WrEn}, 32'd1);
    // stall-causing pattern must be masked while reset is low
    E_A3 = 5'd8; E_Tnew = 2'd2; D_rs = 5'd8; D_rs_Tuse = 2'd1;
    #1;
    check_stall("rst.mask", 1'b0);
    step();
    reset = 1'b1;
    idle_inputs();
    step();
    check_stall("idle", 1'b0);

    // load-use on rs via E
    E_A3 = 5'd8; E_Tnew = 2'd2; D_rs = 5'd8; D_rs_Tuse = 2'd1;
    #1;
    check_stall("loaduse", 1'b1);
    step();
    E_Tnew = 2'd1;
    #1;
    check_stall("loaduse.next", 1'b0);

    // rt dependency via M
    idle_inputs();
    M_A3 = 5'd9; M_Tnew = 2'd1; D_rt = 5'd9; D_rt_Tuse = 2'd0;
    #1;
    check_stall("rt.m", 1'b1);
    D_rt_Tuse = 2'd3;
    #1;
    check_stall("rt.unused", 1'b0);
    D_rt_Tuse = 2'd0; M_A3 = 5'd10;
    #1;
    check_stall("rt.nomatch", 1'b0);

    // register zero never stalls
    idle_inputs();
    E_A3 = 5'd0; E_Tnew = 2'd2; D_rs = 5'd0; D_rs_Tuse = 2'd0;
    #1;
    check_stall("zero", 1'b0);

    // multiply: start cycle plus 5 busy cycles stall an MD instruction
    idle_inputs();
    step();
    E_md_start = 1'b1; D_is_md = 1'b1;
    #1;
    check("mult.start.busy", {31'd0, md_busy}, 32'd0);
    check_stall("mult.start", 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      E_md_start = 1'b0;
      #1;
      check($sformatf("mult.busy%0d", i), {31'd0, md_busy}, 32'd1);
      check_stall($sformatf("mult.stall%0d", i), 1'b1);
    end
    step();
    check("mult.done", {31'd0, md_busy}, 32'd0);
    check_stall("mult.free", 1'b0);

    // divide: 10 busy cycles, non-MD instruction flows
    idle_inputs();
    E_md_start = 1'b1; E_md_is_div = 1'b1;
    #1;
    check_stall("div.start", 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      E_md_start = 1'b0; E_md_is_div = 1'b0;
      #1;
      check($sformatf("div.busy%0d", i), {31'd0, md_busy}, 32'd1);
      check_stall($sformatf("div.nostall%0d", i), 1'b0);
    end
    step();
    check("div.done", {31'd0, md_busy}, 32'd0);

    // async reset at busy cycle 4 of a divide
    E_md_start = 1'b1; E_md_is_div = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      E_md_start = 1'b0; E_md_is_div = 1'b0;
    end
    check("arst.pre", {31'd0, md_busy}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("arst.busy", {31'd0, md_busy}, 32'd0);
    step();
    #2;
    reset = 1'b1;
    D_is_md = 1'b1;
    #1;
    check_stall("arst.md", 1'b0);
    step();
    check("arst.busy2", {31'd0, md_busy}, 32'd0);
    check_stall("arst.md2", 1'b0);

`ifdef STALL_STAT_EN
    idle_inputs();
    reset = 1'b0;
    step();
    check("stat.rst", stall_cnt, 32'd0);
    reset = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      E_A3 = 5'd8; E_Tnew = 2'd2; D_rs = 5'd8; D_rs_Tuse = 2'd1;
      step();
      idle_inputs();
      step();
    end
    check("stat.lu", stall_cnt, 32'd3);
    E_md_start = 1'b1; D_is_md = 1'b1;
    step();
    E_md_start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    D_is_md = 1'b0;
    step();
    check("stat.total", stall_cnt, 32'd9);
    reset = 1'b0;
    #1;
    check("stat.clr", stall_cnt, 32'd0);
    step();
    reset = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
